// File: rtl/binary_to_decimal.sv
// rtl/binary_to_decimal.sv - iterative Q(INT_BITS).(FRAC_BITS) to BCD converter with valid/ready handshakes
// Define FRAC_ROUND_EN to round the hundredths digit half-up instead of truncating.
module binary_to_decimal #(
    parameter int INT_BITS  = 10,
    parameter int FRAC_BITS = 6
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [INT_BITS+FRAC_BITS-1:0] in_data,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [15:0]                   bcd_int,
    output logic [3:0]                    bcd_tenths,
    output logic [3:0]                    bcd_hundredths
);

    typedef enum logic [2:0] {
        IDLE,
        CONV_INT,
        CONV_FRAC,
`ifdef FRAC_ROUND_EN
        ROUND,
`endif
        DONE
    } state_t;

    state_t                 state_q, state_d;
    logic [INT_BITS-1:0]    int_sh_q, int_sh_d;
    logic [FRAC_BITS-1:0]   frac_acc_q, frac_acc_d;
    logic [15:0]            bcd_q, bcd_d;
    logic [3:0]             tenths_q, tenths_d;
    logic [3:0]             cnt_q, cnt_d;
    logic [15:0]            bcd_int_q, bcd_int_d;
    logic [3:0]             tenths_out_q, tenths_out_d;
    logic [3:0]             hund_out_q, hund_out_d;

    logic [15:0]            adj;
    logic [INT_BITS+15:0]   shifted;
    logic [FRAC_BITS+3:0]   prod;
`ifdef FRAC_ROUND_EN
    logic [3:0]             hund_q, hund_d;
    logic [23:0]            rdig;
    logic                   carry;
`endif

    always_comb begin
        state_d      = state_q;
        int_sh_d     = int_sh_q;
        frac_acc_d   = frac_acc_q;
        bcd_d        = bcd_q;
        tenths_d     = tenths_q;
        cnt_d        = cnt_q;
        bcd_int_d    = bcd_int_q;
        tenths_out_d = tenths_out_q;
        hund_out_d   = hund_out_q;

        // Double-dabble step: add-3 correction on every nibble, then shift.
        adj = bcd_q;
        for (int i = 0; i < 4; i++) begin
            if (adj[4*i +: 4] >= 4'd5) begin
                adj[4*i +: 4] = adj[4*i +: 4] + 4'd3;
            end
        end
        shifted = {adj, int_sh_q} << 1;
        prod    = (FRAC_BITS+4)'(frac_acc_q) * (FRAC_BITS+4)'(10);
`ifdef FRAC_ROUND_EN
        hund_d = hund_q;
        rdig   = {bcd_q, tenths_q, hund_q};
        carry  = frac_acc_q[FRAC_BITS-1];
        for (int k = 0; k < 6; k++) begin
            if (carry) begin
                if (rdig[4*k +: 4] == 4'd9) begin
                    rdig[4*k +: 4] = 4'd0;
                end else begin
                    rdig[4*k +: 4] = rdig[4*k +: 4] + 4'd1;
                    carry = 1'b0;
                end
            end
        end
        if (carry) begin
            rdig = 24'h999999;
        end
`endif

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    int_sh_d   = in_data[INT_BITS+FRAC_BITS-1:FRAC_BITS];
                    frac_acc_d = in_data[FRAC_BITS-1:0];
                    bcd_d      = '0;
                    cnt_d      = '0;
                    state_d    = CONV_INT;
                end
            end
            CONV_INT: begin
                bcd_d    = shifted[INT_BITS+15:INT_BITS];
                int_sh_d = shifted[INT_BITS-1:0];
                cnt_d    = cnt_q + 4'd1;
                if (cnt_q == 4'(INT_BITS-1)) begin
                    cnt_d   = '0;
                    state_d = CONV_FRAC;
                end
            end
            CONV_FRAC: begin
                frac_acc_d = prod[FRAC_BITS-1:0];
                if (cnt_q == 4'd0) begin
                    tenths_d = prod[FRAC_BITS+3:FRAC_BITS];
                    cnt_d    = 4'd1;
                end else begin
`ifdef FRAC_ROUND_EN
                    hund_d       = prod[FRAC_BITS+3:FRAC_BITS];
                    state_d      = ROUND;
`else
                    bcd_int_d    = bcd_q;
                    tenths_out_d = tenths_q;
                    hund_out_d   = prod[FRAC_BITS+3:FRAC_BITS];
                    state_d      = DONE;
`endif
                end
            end
`ifdef FRAC_ROUND_EN
            ROUND: begin
                bcd_int_d    = rdig[23:8];
                tenths_out_d = rdig[7:4];
                hund_out_d   = rdig[3:0];
                state_d      = DONE;
            end
`endif
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            int_sh_q     <= '0;
            frac_acc_q   <= '0;
            bcd_q        <= '0;
            tenths_q     <= '0;
            cnt_q        <= '0;
            bcd_int_q    <= '0;
            tenths_out_q <= '0;
            hund_out_q   <= '0;
`ifdef FRAC_ROUND_EN
            hund_q       <= '0;
`endif
        end else begin
            state_q      <= state_d;
            int_sh_q     <= int_sh_d;
            frac_acc_q   <= frac_acc_d;
            bcd_q        <= bcd_d;
            tenths_q     <= tenths_d;
            cnt_q        <= cnt_d;
            bcd_int_q    <= bcd_int_d;
            tenths_out_q <= tenths_out_d;
            hund_out_q   <= hund_out_d;
`ifdef FRAC_ROUND_EN
            hund_q       <= hund_d;
`endif
        end
    end

    assign in_ready       = (state_q == IDLE);
    assign out_valid      = (state_q == DONE);
    assign bcd_int        = bcd_int_q;
    assign bcd_tenths     = tenths_out_q;
    assign bcd_hundredths = hund_out_q;

endmodule

// File: tb/tb_binary_to_decimal.sv
// tb/tb_binary_to_decimal.sv - directed and random checks of binary_to_decimal against an arithmetic model
module tb_binary_to_decimal;
    localparam int IB = 10;
    localparam int FB = 6;
`ifdef FRAC_ROUND_EN
    localparam bit RND = 1'b1;
`else
    localparam bit RND = 1'b0;
`endif
    localparam int EXP_LAT = IB + 2 + (RND ? 1 : 0);

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [IB+FB-1:0]  in_data = '0;
    logic              out_valid;
    logic              out_ready = 1'b1;
    logic [15:0]       bcd_int;
    logic [3:0]        bcd_tenths;
    logic [3:0]        bcd_hundredths;

    int total = 0;
    int bad = 0;

    binary_to_decimal #(.INT_BITS(IB), .FRAC_BITS(FB)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .bcd_int(bcd_int), .bcd_tenths(bcd_tenths), .bcd_hundredths(bcd_hundredths)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Value in hundredths = int*100 + floor(frac*100/2^FB), optionally rounded half-up.
    function automatic logic [23:0] model(input logic [IB+FB-1:0] v);
        int ip, fp, scaled, rem, val, p;
        logic [23:0] r;
        ip     = int'(v) >> FB;
        fp     = int'(v) % (1 << FB);
        scaled = (fp * 100) / (1 << FB);
        rem    = (fp * 100) % (1 << FB);
        val    = ip * 100 + scaled;
        if (RND && rem >= (1 << (FB - 1))) val++;
        if (val > 999999) val = 999999;
        p = 1;
        for (int k = 0; k < 6; k++) begin
            r[4*k +: 4] = 4'((val / p) % 10);
            p = p * 10;
        end
        return r;
    endfunction

    task automatic convert(input logic [IB+FB-1:0] v, input string tag);
        int lat;
        int waited;
        logic [23:0] exp;
        exp = model(v);
        @(negedge clk);
        in_data  = v;
        in_valid = 1'b1;
        waited   = 0;
        while (!in_ready && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        check({tag, "_accept"}, 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check({tag, "_lat"}, 32'(lat), 32'(EXP_LAT));
        check({tag, "_digits"}, {8'h0, bcd_int, bcd_tenths, bcd_hundredths}, {8'h0, exp});
        if (out_ready) begin
            @(posedge clk);
            #1;
            check({tag, "_release"}, {30'h0, out_valid, in_ready}, 32'h1);
            check({tag, "_hold"}, {8'h0, bcd_int, bcd_tenths, bcd_hundredths}, {8'h0, exp});
        end
    endtask

    initial begin
        logic [IB+FB-1:0] rv;
        logic [23:0] prev;
        int waited;

        repeat (3) @(negedge clk);
        check("reset_ready", 32'(in_ready), 32'd1);
        check("reset_valid", 32'(out_valid), 32'd0);
        check("reset_digits", {8'h0, bcd_int, bcd_tenths, bcd_hundredths}, 32'h0);
        rst_n = 1'b1;

        convert(16'h00F0, "d3_75");
        check("d3_75_const", {16'h0, bcd_int}, 32'h0003);
        convert(16'h0055, "d1_33");
        check("d1_33_const", {24'h0, bcd_tenths, bcd_hundredths}, RND ? 32'h33 : 32'h32);
        convert(16'hFFFF, "dmax");
        check("dmax_const", {8'h0, bcd_int, bcd_tenths, bcd_hundredths}, 32'h102398);

        // Zero with backpressure: result must hold and new requests be ignored.
        out_ready = 1'b0;
        convert(16'h0000, "zero");
        @(negedge clk);
        in_data  = 16'h1234;
        in_valid = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check("stall_state", {30'h0, out_valid, in_ready}, 32'h2);
            check("stall_digits", {8'h0, bcd_int, bcd_tenths, bcd_hundredths}, 32'h0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("unstall_ready", {30'h0, out_valid, in_ready}, 32'h1);

        for (int n = 0; n < 20; n++) begin
            rv = (IB+FB)'($urandom);
            convert(rv, "rand");
        end

        // Reset during CONV_INT must discard the operation and clear the outputs.
        prev = {bcd_int, bcd_tenths, bcd_hundredths};
        @(negedge clk);
        in_data  = 16'h1234;
        in_valid = 1'b1;
        waited = 0;
        while (!in_ready && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check("midop_busy", {30'h0, out_valid, in_ready}, 32'h0);
        check("midop_prev", {8'h0, bcd_int, bcd_tenths, bcd_hundredths}, {8'h0, prev});
        #1;
        rst_n = 1'b0;
        #1;
        check("midop_rst_state", {30'h0, out_valid, in_ready}, 32'h1);
        check("midop_rst_digits", {8'h0, bcd_int, bcd_tenths, bcd_hundredths}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        convert(16'h0280, "d10_00");
        check("d10_00_const", {8'h0, bcd_int, bcd_tenths, bcd_hundredths}, 32'h001000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/binary_to_decimal.md
Name: binary_to_decimal

Overview:
- Sequential converter from unsigned binary fixed-point to BCD digits for the display path.
- Takes a calculator result in Q(INT_BITS).(FRAC_BITS) format and produces four BCD integer digits plus tenths and hundredths digits.
- Sits downstream of the arithmetic unit that consumes decimal_to_binary's Q-format output, and feeds the display driver.
- Iterative and area-small; uses a valid/ready handshake on both sides.

Parameters:
- INT_BITS, 10, integer-part width; legal range 1..13, so the maximum fits in 4 BCD digits.
- FRAC_BITS, 6, fractional-part width; legal range 1..8.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  in_data is valid.
- in_ready  out  1  block can accept a value.
- in_data  in  INT_BITS+FRAC_BITS  unsigned fixed-point value; integer field in the MSBs.
- out_valid  out  1  output digits are valid.
- out_ready  in  1  consumer accepts the output digits.
- bcd_int  out  16  four BCD digits; [15:12] thousands ... [3:0] units.
- bcd_tenths  out  4  BCD tenths digit.
- bcd_hundredths  out  4  BCD hundredths digit.

Behaviour:
- Reset (asynchronous, any state, including mid-conversion): state=IDLE, in_ready=1, out_valid=0, all digit outputs 0, internal registers 0.
- State IDLE:
  - in_ready=1, all other states drive in_ready=0.
  - On in_valid&&in_ready: capture int field to int_sh and frac field to frac_acc, clear the BCD accumulator, iteration counter=0, go to CONV_INT.
- State CONV_INT (double-dabble), one bit per cycle, INT_BITS cycles:
  - First, each BCD nibble >=5 gets +3.
  - Then shift {bcd, int_sh} left by 1.
  - After the last iteration, go to CONV_FRAC.
- State CONV_FRAC, 2 cycles:
  - p = frac_acc*10, width FRAC_BITS+4.
  - digit = p >> FRAC_BITS; frac_acc = p mod 2^FRAC_BITS.
  - Cycle 1 writes tenths; cycle 2 writes hundredths.
  - The remainder after cycle 2 is kept for the optional rounding step.
  - Without rounding, the fraction is truncated toward zero.
- State DONE:
  - out_valid=1; the digits stay stable until out_ready.
  - On out_valid&&out_ready, go to IDLE.
  - in_ready returns on the following cycle; there is no same-cycle back-to-back accept.
- Latency: out_valid rises INT_BITS+2 clocks after the accepting edge (12 clocks at defaults); one extra clock with rounding enabled.
- Throughput: one result per INT_BITS+4 cycles minimum (INT_BITS+5 with rounding enabled).
- in_valid is ignored outside IDLE; the upstream stage must hold data until in_ready.
- out_ready held low indefinitely: the block stalls in DONE, outputs unchanged, and no input is accepted.
- Digit outputs are registered and update only on entry to DONE; between results they hold the previous result.
- A reset asserted mid-conversion discards the operation; no partial output is ever flagged valid.

Optional Feature:
- Macro: FRAC_ROUND_EN.
- When defined:
  - An extra state ROUND sits between CONV_FRAC and DONE.
  - If the final remainder >= 2^(FRAC_BITS-1), increment hundredths, propagating the BCD carry 9->0 through tenths and bcd_int units..thousands.
  - A carry out of thousands saturates all digits to 9999.99.
  - Latency increases by 1.
- When undefined: truncation only, with no ROUND state.

Test Plan:
- Reset values: assert rst_n=0 -> in_ready=1, out_valid=0, bcd_int=0, bcd_tenths=0, bcd_hundredths=0.
- Decimal 3.75: in_data=0x00F0 (3<<6|48) -> after 12 cycles, bcd_int=0x0003, tenths=7, hundredths=5, out_valid=1.
- Truncation vs rounding: in_data=0x0055 (1<<6|21) -> 0001.32 without FRAC_ROUND_EN; 0001.33 with it, on cycle 13.
- Maximum input: in_data=0xFFFF -> bcd_int=0x1023, tenths=9, hundredths=8, with and without rounding (remainder 28 < 32).
- Zero and backpressure:
  - in_data=0 with out_ready held low 5 cycles -> 0000.00 holds stable, in_ready=0, a second in_valid is ignored.
  - Then out_ready=1 -> in_ready=1 on the next cycle.
- Reset mid-operation: pulse rst_n low during CONV_INT cycle 4 -> outputs 0, state IDLE; a new input 0x0280 (10.00) converts correctly to 0010.00.
